// File: rtl/flag_unit.sv
// -----------------------------------------------------------------------------
// flag_unit
//
// Purpose:
//   Producer side of the branch-condition flag interface. Captures the
//   architectural flags {N,V,Z} from the EX-stage ALU result, using a
//   per-opcode update mask. Holds a conditional branch in ID while a
//   flag-writing instruction is still in EX. Keeps two saturating event
//   counters for performance debug.
//
// Ports:
//   clk          in   1   system clock, all state on the rising edge
//   rst_n        in   1   asynchronous active-low reset
//   ex_valid     in   1   a real (non-bubble) instruction occupies EX
//   ex_opcode    in   4   opcode of the EX instruction
//   alu_out      in  16   EX ALU result
//   alu_ovfl     in   1   EX ALU signed-overflow indication
//   stall        in   1   global pipeline stall; EX does not advance
//   flush        in   1   squash the EX instruction (wrong path)
//   br_req       in   1   conditional branch in ID needs F this cycle
//   F            out  3   registered flags {N,V,Z}
//   br_stall     out  1   hold the ID branch; flags are not yet current
//   flag_wr_cnt  out 16   committed flag writes, saturating
//   br_stall_cnt out 16   cycles with br_stall high, saturating
// -----------------------------------------------------------------------------
module flag_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  input  logic [3:0]  ex_opcode,
  input  logic [15:0] alu_out,
  input  logic        alu_ovfl,
  input  logic        stall,
  input  logic        flush,
  input  logic        br_req,
  output logic [2:0]  F,
  output logic        br_stall,
  output logic [15:0] flag_wr_cnt,
  output logic [15:0] br_stall_cnt
);

  // Flag bit positions inside F
  localparam int unsigned ZBit = 0;
  localparam int unsigned VBit = 1;
  localparam int unsigned NBit = 2;

  localparam logic [15:0] CntMax = 16'hFFFF;

  logic [2:0]  flags_q, flags_d;
  logic [15:0] wr_cnt_q, wr_cnt_d;
  logic [15:0] st_cnt_q, st_cnt_d;

  logic [2:0]  upd_mask;
  logic [2:0]  new_flags;
  logic        ex_wr;
  logic        commit;
  logic        hazard;

  // Opcode class decode: arithmetic ops write all three flags, logic and
  // shift/rotate ops write only Z, everything else leaves the flags alone.
  always_comb begin
    upd_mask = 3'b000;
    case (ex_opcode)
      4'b0000, 4'b0001:                   upd_mask = 3'b111;
      4'b0010, 4'b0100, 4'b0101, 4'b0110: upd_mask = 3'b001;
      default:                            upd_mask = 3'b000;
    endcase
  end

  // ex_wr deliberately ignores stall: a stalled writer is still in EX and
  // its result is not yet in F, so the branch must keep waiting. flush
  // removes both the commit and the hazard.
  always_comb begin
    new_flags       = 3'b000;
    new_flags[ZBit] = (alu_out == 16'h0000);
    new_flags[VBit] = alu_ovfl;
    new_flags[NBit] = alu_out[15];

    ex_wr  = ex_valid & ~flush & (upd_mask != 3'b000);
    commit = ex_wr & ~stall;
    // rst_n gating keeps the stall request quiet for the whole reset window
    hazard = br_req & ex_wr & rst_n;

    flags_d = commit ? ((flags_q & ~upd_mask) | (new_flags & upd_mask)) : flags_q;

    wr_cnt_d = wr_cnt_q;
    if (commit && (wr_cnt_q != CntMax)) begin
      wr_cnt_d = wr_cnt_q + 16'd1;
    end

    st_cnt_d = st_cnt_q;
    if (hazard && (st_cnt_q != CntMax)) begin
      st_cnt_d = st_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q  <= 3'b000;
      wr_cnt_q <= 16'h0000;
      st_cnt_q <= 16'h0000;
    end else begin
      flags_q  <= flags_d;
      wr_cnt_q <= wr_cnt_d;
      st_cnt_q <= st_cnt_d;
    end
  end

  assign F            = flags_q;
  assign br_stall     = hazard;
  assign flag_wr_cnt  = wr_cnt_q;
  assign br_stall_cnt = st_cnt_q;

endmodule

// File: tb/tb_flag_unit.sv
// -----------------------------------------------------------------------------
// tb_flag_unit
//
// Directed self-checking bench for flag_unit. Inputs change on the falling
// clock edge; registered outputs are sampled 1 time unit after the rising
// edge, combinational br_stall 1 time unit after inputs settle.
// -----------------------------------------------------------------------------
module tb_flag_unit;

  localparam logic [3:0] OpAdd    = 4'b0000;
  localparam logic [3:0] OpSub    = 4'b0001;
  localparam logic [3:0] OpXor    = 4'b0010;
  localparam logic [3:0] OpRed    = 4'b0011;
  localparam logic [3:0] OpSll    = 4'b0100;
  localparam logic [3:0] OpPaddsb = 4'b0111;
  localparam logic [3:0] Op1010   = 4'b1010;

  logic        clk;
  logic        rst_n;
  logic        ex_valid;
  logic [3:0]  ex_opcode;
  logic [15:0] alu_out;
  logic        alu_ovfl;
  logic        stall;
  logic        flush;
  logic        br_req;
  logic [2:0]  F;
  logic        br_stall;
  logic [15:0] flag_wr_cnt;
  logic [15:0] br_stall_cnt;

  int checks;
  int failures;

  flag_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ex_valid     (ex_valid),
    .ex_opcode    (ex_opcode),
    .alu_out      (alu_out),
    .alu_ovfl     (alu_ovfl),
    .stall        (stall),
    .flush        (flush),
    .br_req       (br_req),
    .F            (F),
    .br_stall     (br_stall),
    .flag_wr_cnt  (flag_wr_cnt),
    .br_stall_cnt (br_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one full set of EX/ID inputs
  task automatic applyStimulus(input logic v, input logic [3:0] op, input logic [15:0] res,
                               input logic ov, input logic st, input logic fl, input logic br);
    ex_valid  = v;
    ex_opcode = op;
    alu_out   = res;
    alu_ovfl  = ov;
    stall     = st;
    flush     = fl;
    br_req    = br;
  endtask

  // Drive inputs on the falling edge, then move to just after the rising edge
  task automatic stepCycle(input logic v, input logic [3:0] op, input logic [15:0] res,
                           input logic ov, input logic st, input logic fl, input logic br);
    @(negedge clk);
    applyStimulus(v, op, res, ov, st, fl, br);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      applyStimulus(1'b1, OpAdd, 16'(i * 16'h4001), i[0], i[1], 1'b0, 1'b1);
      #1;
      checks++;
      if (br_stall !== 1'b0) begin
        failures++;
        $display("[TB] FAIL reset_br_stall cycle %0d: got %b, want 0", i, br_stall);
      end
      @(posedge clk);
      #1;
      checks++;
      if (F !== 3'b000 || flag_wr_cnt !== 16'd0 || br_stall_cnt !== 16'd0) begin
        failures++;
        $display("[TB] FAIL reset_state cycle %0d: F=%b wr=%0d st=%0d, want 000/0/0",
                 i, F, flag_wr_cnt, br_stall_cnt);
      end
    end
    @(negedge clk);
    applyStimulus(1'b0, OpAdd, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (F !== 3'b000 || flag_wr_cnt !== 16'd0) begin
      failures++;
      $display("[TB] FAIL reset_release: F=%b wr=%0d, want 000/0", F, flag_wr_cnt);
    end
  endtask

  task automatic test_add_sub;
    stepCycle(1'b1, OpAdd, 16'h8000, 1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (F !== 3'b110 || flag_wr_cnt !== 16'd1) begin
      failures++;
      $display("[TB] FAIL add_flags: F=%b wr=%0d, want 110/1", F, flag_wr_cnt);
    end
    stepCycle(1'b1, OpSub, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (F !== 3'b001 || flag_wr_cnt !== 16'd2) begin
      failures++;
      $display("[TB] FAIL sub_flags: F=%b wr=%0d, want 001/2", F, flag_wr_cnt);
    end
  endtask

  task automatic test_zmask;
    stepCycle(1'b1, OpAdd, 16'h8000, 1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (F !== 3'b110) begin
      failures++;
      $display("[TB] FAIL zmask_setup: F=%b, want 110", F);
    end
    stepCycle(1'b1, OpXor, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (F !== 3'b111 || flag_wr_cnt !== 16'd4) begin
      failures++;
      $display("[TB] FAIL xor_zonly: F=%b wr=%0d, want 111/4", F, flag_wr_cnt);
    end
    stepCycle(1'b1, OpSll, 16'h0004, 1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (F !== 3'b110 || flag_wr_cnt !== 16'd5) begin
      failures++;
      $display("[TB] FAIL sll_zonly: F=%b wr=%0d, want 110/5", F, flag_wr_cnt);
    end
  endtask

  task automatic test_nonwriting;
    logic [3:0] ops [3];
    ops[0] = OpRed;
    ops[1] = OpPaddsb;
    ops[2] = Op1010;
    for (int i = 0; i < 3; i++) begin
      stepCycle(1'b1, ops[i], 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (F !== 3'b110 || flag_wr_cnt !== 16'd5) begin
        failures++;
        $display("[TB] FAIL nonwrite_op%b: F=%b wr=%0d, want 110/5", ops[i], F, flag_wr_cnt);
      end
    end
    stepCycle(1'b0, OpAdd, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (F !== 3'b110 || flag_wr_cnt !== 16'd5) begin
      failures++;
      $display("[TB] FAIL invalid_add: F=%b wr=%0d, want 110/5", F, flag_wr_cnt);
    end
    // flushed ADD, then flush together with stall; branch waiting in both
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      applyStimulus(1'b1, OpAdd, 16'h0000, 1'b0, i[0], 1'b1, 1'b1);
      #1;
      checks++;
      if (br_stall !== 1'b0) begin
        failures++;
        $display("[TB] FAIL flush_hazard stall=%0d: got %b, want 0", i, br_stall);
      end
      @(posedge clk);
      #1;
      checks++;
      if (F !== 3'b110 || flag_wr_cnt !== 16'd5 || br_stall_cnt !== 16'd0) begin
        failures++;
        $display("[TB] FAIL flush_commit stall=%0d: F=%b wr=%0d st=%0d, want 110/5/0",
                 i, F, flag_wr_cnt, br_stall_cnt);
      end
    end
  endtask

  task automatic test_hazard_stall;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      applyStimulus(1'b1, OpAdd, 16'h0000, 1'b0, (i < 3), 1'b0, 1'b1);
      #1;
      checks++;
      if (br_stall !== 1'b1) begin
        failures++;
        $display("[TB] FAIL hazard_br_stall cycle %0d: got %b, want 1", i, br_stall);
      end
      @(posedge clk);
      #1;
      if (i < 3) begin
        checks++;
        if (F !== 3'b110 || flag_wr_cnt !== 16'd5) begin
          failures++;
          $display("[TB] FAIL hazard_hold cycle %0d: F=%b wr=%0d, want 110/5", i, F, flag_wr_cnt);
        end
      end
    end
    checks++;
    if (F !== 3'b001 || flag_wr_cnt !== 16'd6 || br_stall_cnt !== 16'd4) begin
      failures++;
      $display("[TB] FAIL hazard_commit: F=%b wr=%0d st=%0d, want 001/6/4",
               F, flag_wr_cnt, br_stall_cnt);
    end
    @(negedge clk);
    applyStimulus(1'b0, OpAdd, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
    #1;
    checks++;
    if (br_stall !== 1'b0) begin
      failures++;
      $display("[TB] FAIL hazard_release: got %b, want 0", br_stall);
    end
    @(posedge clk);
    #1;
    checks++;
    if (br_stall_cnt !== 16'd4 || F !== 3'b001) begin
      failures++;
      $display("[TB] FAIL hazard_after: st=%0d F=%b, want 4/001", br_stall_cnt, F);
    end
  endtask

  task automatic test_back_to_back;
    stepCycle(1'b1, OpAdd, 16'h8000, 1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (F !== 3'b100 || flag_wr_cnt !== 16'd7) begin
      failures++;
      $display("[TB] FAIL b2b_first: F=%b wr=%0d, want 100/7", F, flag_wr_cnt);
    end
    @(negedge clk);
    applyStimulus(1'b1, OpXor, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1);
    #1;
    checks++;
    if (br_stall !== 1'b1) begin
      failures++;
      $display("[TB] FAIL b2b_br_stall: got %b, want 1", br_stall);
    end
    @(posedge clk);
    #1;
    checks++;
    if (F !== 3'b101 || flag_wr_cnt !== 16'd8 || br_stall_cnt !== 16'd6) begin
      failures++;
      $display("[TB] FAIL b2b_second: F=%b wr=%0d st=%0d, want 101/8/6",
               F, flag_wr_cnt, br_stall_cnt);
    end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    applyStimulus(1'b1, OpAdd, 16'h8000, 1'b1, 1'b0, 1'b0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (F !== 3'b000 || flag_wr_cnt !== 16'd0 || br_stall_cnt !== 16'd0 || br_stall !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_mid: F=%b wr=%0d st=%0d brs=%b, want 000/0/0/0",
               F, flag_wr_cnt, br_stall_cnt, br_stall);
    end
    @(posedge clk);
    #1;
    checks++;
    if (F !== 3'b000 || flag_wr_cnt !== 16'd0) begin
      failures++;
      $display("[TB] FAIL reset_mid_lost: F=%b wr=%0d, want 000/0", F, flag_wr_cnt);
    end
    @(negedge clk);
    applyStimulus(1'b0, OpAdd, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
  endtask

  task automatic test_saturation;
    @(negedge clk);
    applyStimulus(1'b1, OpAdd, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (65535) @(posedge clk);
    #1;
    checks++;
    if (flag_wr_cnt !== 16'hFFFF || br_stall_cnt !== 16'hFFFF) begin
      failures++;
      $display("[TB] FAIL sat_reach: wr=%h st=%h, want FFFF/FFFF", flag_wr_cnt, br_stall_cnt);
    end
    repeat (100) @(posedge clk);
    #1;
    checks++;
    if (flag_wr_cnt !== 16'hFFFF || br_stall_cnt !== 16'hFFFF || F !== 3'b000) begin
      failures++;
      $display("[TB] FAIL sat_hold: wr=%h st=%h F=%b, want FFFF/FFFF/000",
               flag_wr_cnt, br_stall_cnt, F);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    applyStimulus(1'b0, OpAdd, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    test_reset();
    test_add_sub();
    test_zmask();
    test_nonwriting();
    test_hazard_stall();
    test_back_to_back();
    test_reset_mid();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
